// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential unsigned multiplier. It retires one multiplier bit per clock,
//   so a WIDTH x WIDTH multiply takes WIDTH RUN cycles and then one DONE cycle.
//
//   Parameters
//     WIDTH    operand width in bits, 2..16 (default 8)
//
//   Ports
//     clk      clock; all state updates on the rising edge
//     rst_n    asynchronous active-low reset
//     start    begin a multiply; sampled only while ready=1
//     abort    cancel an in-progress multiply (acts only in RUN)
//     a, b     unsigned multiplicand and multiplier, latched at the start edge
//     ready    high in IDLE
//     busy     high in RUN
//     done     one-cycle pulse; product is valid in the same cycle
//     product  a*b of the last completed multiply; held until the next one
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    // Upper half is the running partial sum. The lower half starts as the
    // multiplier and is consumed LSB-first while product bits shift in above it.
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] acc_d;
    logic               last_d;

    always_comb begin
        // The carry-out lands in bit WIDTH of the sum. It is kept through the
        // shift, so no bit of the partial product is lost.
        sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_d  = {sum_d, acc_q[WIDTH-1:1]};
        last_d = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // abort has no meaning here; start alone decides
                    if (start) begin
                        mcand_q <= a;
                        acc_q   <= {{WIDTH{1'b0}}, b};
                        cnt_q   <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_d) begin
                            product_q <= acc_d;
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks   = 0;
    int failures = 0;
    int ndone    = 0;
    int cyc      = 0;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) ndone <= ndone + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic go(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
    endtask

    // Returns the number of negedges until done is seen and how many of
    // them had busy high. start/abort are dropped after the first edge.
    task automatic wait_done(output int lat, output int nbusy);
        bit got;
        got   = 0;
        lat   = 0;
        nbusy = 0;
        for (int i = 1; i <= 30; i++) begin
            if (!got) begin
                @(negedge clk);
                start = 1'b0;
                abort = 1'b0;
                if (done) begin
                    got = 1;
                    lat = i;
                end else if (busy) begin
                    nbusy++;
                end
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int lat, nb, d0, tprev, tcur;
    logic [7:0] blist [14];

    initial begin
        blist = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15, 8'd16, 8'd85,
                  8'd127, 8'd128, 8'd170, 8'd200, 8'd254, 8'd255};
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready",   32'(ready),   32'd1);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;

        // 255*255, first start right after reset release
        go(8'd255, 8'd255);
        wait_done(lat, nb);
        chk("max_busy_cycles", 32'(nb),      32'd8);
        chk("max_latency",     32'(lat),     32'd9);
        chk("max_product",     32'(product), 32'hFE01);
        @(negedge clk);
        chk("max_ready_after", 32'(ready),   32'd1);
        chk("max_done_1cyc",   32'(done),    32'd0);
        chk("max_prod_hold",   32'(product), 32'hFE01);

        // zero operand still takes the full run
        go(8'd0, 8'd200);
        wait_done(lat, nb);
        chk("zero_latency", 32'(lat),     32'd9);
        chk("zero_product", 32'(product), 32'd0);
        @(negedge clk);
        go(8'd1, 8'd1);
        wait_done(lat, nb);
        chk("one_product", 32'(product), 32'd1);
        @(negedge clk);

        // operands and start changed mid-run are ignored
        d0 = ndone;
        go(8'd13, 8'd11);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_prod_hold", 32'(product), 32'd1);
        a = 8'd99; b = 8'd99; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(lat, nb);
        chk("ign_latency", 32'(lat),     32'd5);
        chk("ign_product", 32'(product), 32'd143);
        @(negedge clk);
        repeat (12) @(negedge clk);
        chk("ign_one_done", 32'(ndone - d0), 32'd1);
        chk("ign_idle",     32'(ready),      32'd1);

        // abort in the fourth RUN cycle
        d0 = ndone;
        go(8'd200, 8'd3);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy",  32'(busy),  32'd0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(ndone - d0), 32'd0);
        chk("abort_prod",    32'(product),    32'd143);

        // reset in the fifth RUN cycle
        d0 = ndone;
        go(8'd170, 8'd85);
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_ready",   32'(ready),   32'd1);
        chk("mrst_busy",    32'(busy),    32'd0);
        chk("mrst_done",    32'(done),    32'd0);
        chk("mrst_product", 32'(product), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mrst_no_done", 32'(ndone - d0), 32'd0);
        go(8'd170, 8'd85);
        wait_done(lat, nb);
        chk("mrst_restart", 32'(product), 32'd14450);
        @(negedge clk);

        // abort in IDLE does nothing
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ready", 32'(ready),   32'd1);
        chk("idle_abort_prod",  32'(product), 32'd14450);

        // abort together with start in IDLE: start wins
        abort = 1'b1;
        go(8'd7, 8'd9);
        wait_done(lat, nb);
        chk("abst_latency", 32'(lat),     32'd9);
        chk("abst_product", 32'(product), 32'd63);

        // abort during DONE does nothing
        @(negedge clk);
        go(8'd5, 8'd6);
        wait_done(lat, nb);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("done_abort_ready", 32'(ready),   32'd1);
        chk("done_abort_prod",  32'(product), 32'd30);

        // back-to-back sweep; done pulses 10 cycles apart
        tprev = -1;
        for (int ai = 0; ai <= 255; ai += 5) begin
            for (int bi = 0; bi < 14; bi++) begin
                @(negedge clk);
                go(8'(ai), blist[bi]);
                wait_done(lat, nb);
                tcur = cyc;
                chk($sformatf("sweep_%0d_%0d", ai, blist[bi]), 32'(product), 32'(ai) * 32'(blist[bi]));
                if (tprev >= 0) chk("sweep_spacing", 32'(tcur - tprev), 32'd10);
                tprev = tcur;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
